keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Drives the physical 4x4 hex keypad and produces the debounced keypad_matrix[15:0] consumed by cpu.
//  Scans one row at a time (active-low row drive, pulled-up active-low columns).
//  Synchronises and debounces every key, and flags newly pressed keys for Fx0A (wait-for-key).
//  Sits at top level between board pins and cpu.keypad_matrix, replacing the tie-off to 0.
// PARAMETERS
//  SCAN_DIV  16'd1000  clk cycles per row slot; legal range >= 4
//  DEBOUNCE  4'd4      consecutive identical samples needed to flip a key state; legal range 1..15
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high
//  col_sense      in   4   raw keypad columns, active-low, asynchronous to clk
//  row_drive      out  4   row strobes, active-low one-hot; bit r drives row r
//  keypad_matrix  out  16  debounced key state, 1 = pressed; bit index = row*4 + col
//  key_down       out  1   one-cycle pulse: at least one key went released->pressed
//  key_down_idx   out  4   index of that key; valid only while key_down = 1
//  scan_wrap      out  1   one-cycle pulse on the last slot of row 3 (frame marker)
// BEHAVIOUR
//  Reset (sync, highest priority, allowed mid-scan):
//   row=0, row_drive=4'b1110, div_cnt=0, sync flops=4'b1111, all per-key counters=0,
//   keypad_matrix=0, key_down=0, key_down_idx=0, scan_wrap=0.
//  Input sync: col_sense passes through 2 flops -> col_s. pressed_raw[c] = ~col_s[c].
//  Slot timer:
//   div_cnt counts 0..SCAN_DIV-1, then wraps to 0.
//   "Tick" is the cycle where div_cnt == SCAN_DIV-1.
//  On tick:
//   - sample: for c in 0..3, key k = row*4+c takes sample pressed_raw[c].
//   - row advances (row+1 mod 4); row_drive updates the same edge.
//   - next row settles for SCAN_DIV-1 cycles before it is sampled (>= 3 incl. sync).
//  Debounce (per key, 4-bit counter cnt[k], evaluated only on ticks for the 4 sampled keys):
//   - sample == keypad_matrix[k]: cnt[k] <= 0.
//   - sample != state and cnt[k]+1 == DEBOUNCE: keypad_matrix[k] flips; cnt[k] <= 0.
//   - otherwise: cnt[k] <= cnt[k]+1.
//   - So a key changes state after DEBOUNCE consecutive frames of the new level.
//   - A mismatch run interrupted by one matching sample restarts from 0.
//   - Unsampled keys hold state and count.
//  key_down / key_down_idx:
//   - Registered; asserted the cycle after the tick in which >= 1 sampled key flipped 0->1.
//   - idx = lowest such row*4+c.
//   - Releases never pulse.
//   - Keys in the same row flipping together give one pulse (lowest index); all bits still set.
//  scan_wrap: registered; asserted the cycle after the row-3 tick.
//  Latency: keypad_matrix reflects a flip on the cycle after the deciding tick.
//   Worst case from a stable press: 2 sync + DEBOUNCE*4*SCAN_DIV cycles.
//  Simultaneous press/release in one row on one tick: each key is handled independently.
//  All outputs are registered; no combinational path from col_sense.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE=3; frame = 16 cycles; key k tick = row(k)*4+3 within frame)
//  1. Reset, col_sense=4'hF -> row_drive cycles 1110,1101,1011,0111 every 4 clk;
//     scan_wrap pulses every 16 clk; keypad_matrix=0.
//  2. Hold key 5 (col_sense[1]=0 while row_drive[1]=0) -> keypad_matrix=16'h0020 on the 3rd row-1 tick;
//     key_down=1, key_down_idx=5 for exactly 1 cycle.
//  3. Key 5 held for 2 frames only -> keypad_matrix stays 0, key_down never asserts;
//     release after set needs 3 frames to clear, with no pulse.
//  4. Keys 9 and 11 (row 2, cols 1,3) pressed together -> both bits set on the same cycle (16'h0A00);
//     single key_down with idx=9.
//  5. Bounce: key 0 pattern pressed,pressed,released,pressed x3 over frames -> set only after the last 3 consecutive.
//  6. Assert reset mid-slot with keys 5 and 9 latched ->
//     next cycle keypad_matrix=0, row_drive=1110, div_cnt=0; rescan re-latches after 3 frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives a 4x4 hex keypad one row at a time, synchronises the
// active-low column returns, debounces each key across scan frames and emits
// a one-cycle press pulse plus a frame marker. All outputs are registered.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV = 16'd1000,  // clk cycles per row slot, >= 4
  parameter logic [3:0]  DEBOUNCE = 4'd4       // consecutive frames to flip, 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col_sense,
  output logic [3:0]  row_drive,
  output logic [15:0] keypad_matrix,
  output logic        key_down,
  output logic [3:0]  key_down_idx,
  output logic        scan_wrap
);

  logic [3:0]  sync1_q, col_s_q;
  logic [15:0] div_cnt_q;
  logic [1:0]  row_q;
  logic [3:0]  row_drive_q;
  logic [3:0]  cnt_q [16];
  logic [3:0]  cnt_d [16];
  logic [15:0] matrix_q, matrix_d;
  logic        key_down_q, key_down_d;
  logic [3:0]  idx_q, idx_d;
  logic        wrap_q;
  logic        tick;

  // Last cycle of a row slot: the driven row has settled and is sampled.
  assign tick = (div_cnt_q == SCAN_DIV - 16'd1);

  // Debounce the four keys of the current row; lowest newly pressed key wins the pulse.
  always_comb begin
    logic [3:0] k;
    logic       s;
    matrix_d   = matrix_q;
    cnt_d      = cnt_q;
    key_down_d = 1'b0;
    idx_d      = 4'd0;
    k          = 4'd0;
    s          = 1'b0;
    if (tick) begin
      for (int c = 0; c < 4; c++) begin
        k = {row_q, 2'(c)};
        s = ~col_s_q[c];
        if (s == matrix_q[k]) begin
          cnt_d[k] = 4'd0;
        end else if (cnt_q[k] + 4'd1 == DEBOUNCE) begin
          matrix_d[k] = s;
          cnt_d[k]    = 4'd0;
          if (s && !key_down_d) begin
            key_down_d = 1'b1;
            idx_d      = k;
          end
        end else begin
          cnt_d[k] = cnt_q[k] + 4'd1;
        end
      end
    end
  end

  // Sync chain, slot timer, row strobe and registered outputs; reset overrides all.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 4'hF;
      col_s_q     <= 4'hF;
      div_cnt_q   <= 16'd0;
      row_q       <= 2'd0;
      row_drive_q <= 4'b1110;
      cnt_q       <= '{default: 4'd0};
      matrix_q    <= 16'd0;
      key_down_q  <= 1'b0;
      idx_q       <= 4'd0;
      wrap_q      <= 1'b0;
    end else begin
      sync1_q    <= col_sense;
      col_s_q    <= sync1_q;
      div_cnt_q  <= tick ? 16'd0 : div_cnt_q + 16'd1;
      if (tick) begin
        row_q       <= row_q + 2'd1;
        row_drive_q <= ~(4'b0001 << (row_q + 2'd1));
      end
      cnt_q      <= cnt_d;
      matrix_q   <= matrix_d;
      key_down_q <= key_down_d;
      idx_q      <= idx_d;
      wrap_q     <= tick && (row_q == 2'd3);
    end
  end

  assign row_drive     = row_drive_q;
  assign keypad_matrix = matrix_q;
  assign key_down      = key_down_q;
  assign key_down_idx  = idx_q;
  assign scan_wrap     = wrap_q;

endmodule
